// File: rtl/safe_pkg.sv
// Shared types and helpers for the safe code checker: state encodings, code width, BCD check.
package safe_pkg;

    localparam int unsigned CODE_W  = 16;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned NIBBLES = CODE_W / 4;

    typedef enum logic [2:0] {
        ST_LOCKED      = 3'd0,
        ST_UNLOCKED    = 3'd1,
        ST_SET_NEW     = 3'd2,
        ST_SET_CONFIRM = 3'd3,
        ST_LOCKOUT     = 3'd4
    } state_e;

    // True when every nibble of the code is a decimal digit.
    function automatic logic bcd_valid(input logic [CODE_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (v[4*i +: 4] > 4'(BCD_MAX)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down counter shared by the lockout and auto-relock timeouts; holds at zero.
module safe_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/safe_code_checker.sv
// Digital safe code checker: unlock, failed-attempt lockout, confirmed code change, auto-relock.
module safe_code_checker
    import safe_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 16'h0000,
    parameter int unsigned       MAX_FAIL       = 3,
    parameter int unsigned       LOCKOUT_CYCLES = 100_000_000,
    parameter int unsigned       UNLOCK_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic       set_mode,
    input  logic [3:0] dec1,
    input  logic [3:0] dec2,
    input  logic [3:0] dec3,
    input  logic [3:0] dec4,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [2:0] mode,
    output logic       code_changed,
    output logic       code_err
);

    localparam int unsigned MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] UNLOCK_LD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       FAIL_MAX   = 2'(MAX_FAIL);

    state_e            state, nxt_state;
    logic [CODE_W-1:0] code, nxt_code;
    logic [CODE_W-1:0] cand, nxt_cand;
    logic [1:0]        nxt_fail;
    logic              nxt_changed, nxt_err;
    logic [CODE_W-1:0] entry;
    logic              entry_ok;
    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_val_c;
    logic              tmr_done;

    safe_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done     (tmr_done)
    );

    assign entry    = {dec4, dec3, dec2, dec1};
    assign entry_ok = bcd_valid(entry);

    // Next-state decode; timer expiry in a timed state takes precedence over enter.
    always_comb begin
        nxt_state   = state;
        nxt_code    = code;
        nxt_cand    = cand;
        nxt_fail    = fail_cnt;
        nxt_changed = 1'b0;
        nxt_err     = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_val_c   = '0;
        case (state)
            ST_LOCKED: begin
                if (enter) begin
                    if (entry_ok && entry == code) begin
                        nxt_state  = ST_UNLOCKED;
                        nxt_fail   = 2'd0;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = UNLOCK_LD;
                    end else begin
                        nxt_err  = !entry_ok;
                        nxt_fail = fail_cnt + 2'd1;
                        if (nxt_fail == FAIL_MAX) begin
                            nxt_state  = ST_LOCKOUT;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = LOCKOUT_LD;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                if (tmr_done || enter) begin
                    nxt_state  = ST_LOCKED;
                    tmr_load_c = 1'b1;
                end else if (set_mode) begin
                    nxt_state  = ST_SET_NEW;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = UNLOCK_LD;
                end
            end
            ST_SET_NEW: begin
                if (tmr_done) begin
                    nxt_state  = ST_LOCKED;
                    nxt_cand   = '0;
                    tmr_load_c = 1'b1;
                end else if (enter) begin
                    if (entry_ok) begin
                        nxt_cand   = entry;
                        nxt_state  = ST_SET_CONFIRM;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = UNLOCK_LD;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            ST_SET_CONFIRM: begin
                if (tmr_done) begin
                    nxt_state  = ST_LOCKED;
                    nxt_cand   = '0;
                    tmr_load_c = 1'b1;
                end else if (enter) begin
                    if (entry == cand) begin
                        nxt_code    = cand;
                        nxt_changed = 1'b1;
                    end else begin
                        nxt_err = 1'b1;
                    end
                    nxt_cand   = '0;
                    nxt_state  = ST_UNLOCKED;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = UNLOCK_LD;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    nxt_state = ST_LOCKED;
                    nxt_fail  = 2'd0;
                end
            end
            default: begin
                nxt_state  = ST_LOCKED;
                tmr_load_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_LOCKED;
            code         <= DEFAULT_CODE;
            cand         <= '0;
            fail_cnt     <= 2'd0;
            unlocked     <= 1'b0;
            alarm        <= 1'b0;
            code_changed <= 1'b0;
            code_err     <= 1'b0;
        end else begin
            state        <= nxt_state;
            code         <= nxt_code;
            cand         <= nxt_cand;
            fail_cnt     <= nxt_fail;
            unlocked     <= (nxt_state == ST_UNLOCKED) || (nxt_state == ST_SET_NEW) ||
                            (nxt_state == ST_SET_CONFIRM);
            alarm        <= (nxt_state == ST_LOCKOUT);
            code_changed <= nxt_changed;
            code_err     <= nxt_err;
        end
    end

    assign mode = state;

endmodule
